bi_set_arbiter: RTL

//  Shares one BiSet configuration bus master port (setCtrl/setWrite/setReply) between
//  N_REQ requesters via round-robin arbitration. Each requester posts one read or write

---
 rtl/bi_set_arbiter_pkg.sv | 42 ++++
 rtl/bi_set_arbiter_rr_pick.sv | 36 +++
 rtl/bi_set_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bi_set_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bi_set_arbiter_pkg
//  BiSet configuration bus types shared by the arbiter and its sub-module.
//  biSetAddr   : register address on the BiSet bus
//  biSetData   : write / read data word
//  biSetReply  : slave read reply word
//  biSetCtrl   : bus command {vld, we, addr}; all-zero means "no command"
//  BiSetCtrl() : builds a valid command from (we, addr)
//  biSetArbState : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package bi_set_arbiter_pkg;

  localparam int BISET_ADDR_W = 8;
  localparam int BISET_DATA_W = 16;

  typedef logic [BISET_ADDR_W-1:0] biSetAddr;
  typedef logic [BISET_DATA_W-1:0] biSetData;
  typedef logic [BISET_DATA_W-1:0] biSetReply;

  // The vld bit keeps a read of address 0 distinguishable from an idle bus.
  typedef struct packed {
    logic     vld;
    logic     we;
    biSetAddr addr;
  } biSetCtrl;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } biSetArbState;

  function automatic biSetCtrl BiSetCtrl(input logic we, input biSetAddr addr);
    biSetCtrl c;
    c.vld  = 1'b1;
    c.we   = we;
    c.addr = addr;
    return c;
  endfunction

endpackage

// File: rtl/bi_set_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// bi_set_rr_pick
//  Combinational round-robin selector: returns the lowest-indexed active
//  request at or after the pointer, wrapping past N_REQ-1 back to 0.
//  req_i    in  N_REQ  request vector
//  ptr_i    in  PTR_W  round-robin start index (always < N_REQ)
//  winner_o out PTR_W  selected requester index (0 when none)
//  any_o    out 1      at least one request active
// ---------------------------------------------------------------------------
module bi_set_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] winner_o,
  output logic             any_o
);

  // Scan offsets from farthest to nearest so the nearest active request
  // (smallest offset from the pointer) is the last one written.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (req_i[idx]) begin
        winner_o = PTR_W'(idx);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bi_set_arbiter.sv
// ---------------------------------------------------------------------------
// bi_set_arbiter
//  Round-robin arbiter sharing one BiSet bus master port between N_REQ
//  requesters. Each requester holds req until a one-cycle ack; reads return
//  data on rdata_o in the ack cycle. All outputs are registered.
//  clk_i       in   clock
//  rst_i       in   asynchronous active-low reset
//  req_i       in   N_REQ        request per requester (level, held to ack)
//  we_i        in   N_REQ        1=write 0=read
//  addr_i      in   N_REQ x addr address per requester
//  wdata_i     in   N_REQ x data write data per requester
//  ack_o       out  N_REQ        completion pulse, one-hot or zero
//  rdata_o     out  data         last read value, valid in the ack cycle
//  busy_o      out  1            high whenever the FSM is not IDLE
//  setCtrl_o   out  ctrl         bus command, zero when no command
//  setWrite_o  out  data         bus write data, zero outside write commands
//  setReply_i  in   reply        bus read reply
//  Parameters: N_REQ requesters; REPLY_LAT cycles from command to reply.
// ---------------------------------------------------------------------------
module bi_set_arbiter
  import bi_set_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int REPLY_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic     [N_REQ-1:0] req_i,
  input  logic     [N_REQ-1:0] we_i,
  input  biSetAddr [N_REQ-1:0] addr_i,
  input  biSetData [N_REQ-1:0] wdata_i,
  output logic     [N_REQ-1:0] ack_o,
  output biSetData             rdata_o,
  output logic                 busy_o,
  output biSetCtrl             setCtrl_o,
  output biSetData             setWrite_o,
  input  biSetReply            setReply_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (REPLY_LAT > 1) ? $clog2(REPLY_LAT) : 1;

  biSetArbState     state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

  // Pointer advances to the requester after the one just served.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] w);
    if (int'(w) >= N_REQ - 1) return '0;
    return w + PTR_W'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] w);
    return N_REQ'(1) << w;
  endfunction

  bi_set_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .any_o    (pick_any)
  );

  // Only the winner index and direction are latched: address and write data
  // go straight into the registered bus command, so later changes on the
  // requester's inputs cannot disturb a granted transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      ack_o      <= '0;
      rdata_o    <= '0;
      busy_o     <= 1'b0;
      setCtrl_o  <= '0;
      setWrite_o <= '0;
    end else begin
      ack_o <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            win_q      <= pick_idx;
            we_q       <= we_i[pick_idx];
            setCtrl_o  <= BiSetCtrl(we_i[pick_idx], addr_i[pick_idx]);
            setWrite_o <= we_i[pick_idx] ? wdata_i[pick_idx] : '0;
            busy_o     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          setCtrl_o  <= '0;
          setWrite_o <= '0;
          if (we_q) begin
            ack_o   <= onehot(win_q);
            state_q <= ACK;
          end else begin
            cnt_q   <= CNT_W'(REPLY_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Reply is sampled on the edge closing the last wait cycle.
          if (cnt_q == '0) begin
            rdata_o <= setReply_i;
            ack_o   <= onehot(win_q);
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          ptr_q   <= ptr_next(win_q);
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
